// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Registered parametrised ALU with a start/done handshake.
//                Logic, arithmetic, shift and rotate ops finish in one cycle.
//                Signed multiply (radix-2 Booth) and signed divide (restoring)
//                iterate for DATA_WIDTH cycles. Result is {HI, LO}.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      start,
    input  logic [3:0]                op,
    input  logic [DATA_WIDTH-1:0]     A,
    input  logic [DATA_WIDTH-1:0]     B,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   result,
    output logic                      div_by_zero
);

    localparam int c_W  = DATA_WIDTH;
    localparam int c_SH = $clog2(c_W);
    // W is a power of two, so the final iteration index W-1 is all ones
    localparam logic [c_SH-1:0] c_LAST = '1;

    localparam logic [3:0] c_OP_OR   = 4'd0;
    localparam logic [3:0] c_OP_AND  = 4'd1;
    localparam logic [3:0] c_OP_XOR  = 4'd2;
    localparam logic [3:0] c_OP_NOT  = 4'd3;
    localparam logic [3:0] c_OP_ADD  = 4'd4;
    localparam logic [3:0] c_OP_SUB  = 4'd5;
    localparam logic [3:0] c_OP_NEG  = 4'd6;
    localparam logic [3:0] c_OP_SHL  = 4'd7;
    localparam logic [3:0] c_OP_SHR  = 4'd8;
    localparam logic [3:0] c_OP_SHRA = 4'd9;
    localparam logic [3:0] c_OP_ROL  = 4'd10;
    localparam logic [3:0] c_OP_ROR  = 4'd11;
    localparam logic [3:0] c_OP_MUL  = 4'd12;
    localparam logic [3:0] c_OP_DIV  = 4'd13;
    localparam logic [3:0] c_OP_PASS = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_SH-1:0]   r_cnt;
    // Iteration datapath shared by MUL and DIV:
    //   MUL: r_acc = Booth accumulator (W+1 bits so -2^(W-1) multiplicand is safe),
    //        r_lo = multiplier/low product, r_qm1 = Booth q(-1), r_opnd = multiplicand.
    //   DIV: r_acc[W-1:0] = partial remainder, r_lo = dividend shifting into quotient,
    //        r_opnd = {0, |divisor|}.
    logic [c_W:0]      r_acc;
    logic [c_W-1:0]    r_lo;
    logic              r_qm1;
    logic [c_W:0]      r_opnd;
    logic              r_sign_q;
    logic              r_sign_r;

    // ---------------- single-cycle operations ----------------
    logic [c_SH-1:0]   w_amt;
    logic [c_SH-1:0]   w_amt_inv;
    logic [c_W:0]      w_add;
    logic [c_W:0]      w_sub;
    logic [c_W-1:0]    w_shra;
    logic [2*c_W-1:0]  w_single;

    assign w_amt     = B[c_SH-1:0];
    // (W - amt) mod W; amount 0 makes both rotate halves equal to A, which is correct
    assign w_amt_inv = '0 - w_amt;
    assign w_add     = {1'b0, A} + {1'b0, B};
    assign w_sub     = {1'b0, A} - {1'b0, B};
    assign w_shra    = $signed(A) >>> w_amt;

    // Result of every op that completes at the capture edge
    always_comb begin
        w_single = '0;
        case (op)
            c_OP_OR:   w_single[c_W-1:0] = A | B;
            c_OP_AND:  w_single[c_W-1:0] = A & B;
            c_OP_XOR:  w_single[c_W-1:0] = A ^ B;
            c_OP_NOT:  w_single[c_W-1:0] = ~A;
            c_OP_ADD:  w_single[c_W:0]   = w_add;
            c_OP_SUB:  w_single[c_W:0]   = w_sub;
            c_OP_NEG:  w_single[c_W-1:0] = '0 - A;
            c_OP_SHL:  w_single[c_W-1:0] = A << w_amt;
            c_OP_SHR:  w_single[c_W-1:0] = A >> w_amt;
            c_OP_SHRA: w_single[c_W-1:0] = w_shra;
            c_OP_ROL:  w_single[c_W-1:0] = (A << w_amt) | (A >> w_amt_inv);
            c_OP_ROR:  w_single[c_W-1:0] = (A >> w_amt) | (A << w_amt_inv);
            c_OP_PASS: w_single[c_W-1:0] = B;
            default:   w_single = '0;
        endcase
    end

    // ---------------- operand magnitudes for DIV ----------------
    logic [c_W-1:0] w_abs_a;
    logic [c_W-1:0] w_abs_b;
    assign w_abs_a = A[c_W-1] ? ('0 - A) : A;
    assign w_abs_b = B[c_W-1] ? ('0 - B) : B;

    // ---------------- Booth step ----------------
    logic [c_W:0]   w_bsum;
    logic [c_W:0]   w_mul_acc;
    logic [c_W-1:0] w_mul_lo;

    // Add or subtract the multiplicand according to the Booth bit pair
    always_comb begin
        w_bsum = r_acc;
        case ({r_lo[0], r_qm1})
            2'b01:   w_bsum = r_acc + r_opnd;
            2'b10:   w_bsum = r_acc - r_opnd;
            default: w_bsum = r_acc;
        endcase
    end

    assign w_mul_acc = {w_bsum[c_W], w_bsum[c_W:1]};
    assign w_mul_lo  = {w_bsum[0], r_lo[c_W-1:1]};

    // ---------------- restoring divide step ----------------
    logic [c_W:0]   w_dshift;
    logic           w_dge;
    logic [c_W-1:0] w_dsub;
    logic [c_W-1:0] w_div_rem;
    logic [c_W-1:0] w_div_lo;
    logic [c_W-1:0] w_quo_fin;
    logic [c_W-1:0] w_rem_fin;

    assign w_dshift  = {r_acc[c_W-1:0], r_lo[c_W-1]};
    assign w_dge     = (w_dshift >= r_opnd);
    // The true difference is below the divisor, so W bits hold it exactly
    assign w_dsub    = w_dshift[c_W-1:0] - r_opnd[c_W-1:0];
    assign w_div_rem = w_dge ? w_dsub : w_dshift[c_W-1:0];
    assign w_div_lo  = {r_lo[c_W-2:0], w_dge};
    // Quotient truncates toward zero; remainder follows the dividend sign.
    // -2^(W-1) / -1 yields magnitude 2^(W-1), which reads back as -2^(W-1).
    assign w_quo_fin = r_sign_q ? ('0 - w_div_lo)  : w_div_lo;
    assign w_rem_fin = r_sign_r ? ('0 - w_div_rem) : w_div_rem;

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
            r_qm1       <= 1'b0;
            r_opnd      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op == c_OP_MUL) begin
                            r_acc   <= '0;
                            r_lo    <= B;
                            r_qm1   <= 1'b0;
                            r_opnd  <= {A[c_W-1], A};
                            r_cnt   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_MUL;
                        end else if (op == c_OP_DIV && B != '0) begin
                            r_acc    <= '0;
                            r_lo     <= w_abs_a;
                            r_opnd   <= {1'b0, w_abs_b};
                            r_sign_q <= A[c_W-1] ^ B[c_W-1];
                            r_sign_r <= A[c_W-1];
                            r_cnt    <= '0;
                            busy     <= 1'b1;
                            r_state  <= S_DIV;
                        end else if (op == c_OP_DIV) begin
                            result      <= {A, {c_W{1'b1}}};
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            result      <= w_single;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_acc;
                    r_lo  <= w_mul_lo;
                    r_qm1 <= r_lo[0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        result      <= {w_mul_acc[c_W-1:0], w_mul_lo};
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_DIV: begin
                    r_acc <= {1'b0, w_div_rem};
                    r_lo  <= w_div_lo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        result      <= {w_rem_fin, w_quo_fin};
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu (DATA_WIDTH = 32). Stimulus
//                pushes expected responses into a queue; a monitor pops and
//                compares whenever done is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        div_by_zero;

    seq_alu #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] res;
        logic        dbz;
        logic [31:0] due;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: {div_by_zero, result} from plain arithmetic
    function automatic logic [64:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        logic        z;
        logic [31:0] x;
        longint      q;
        longint      m;
        int          amt;
        r   = '0;
        z   = 1'b0;
        x   = a;
        amt = int'(b[4:0]);
        case (o)
            4'd0:  r = {32'b0, a | b};
            4'd1:  r = {32'b0, a & b};
            4'd2:  r = {32'b0, a ^ b};
            4'd3:  r = {32'b0, ~a};
            4'd4:  r = {32'b0, a} + {32'b0, b};
            4'd5:  begin x = a - b; r = {31'b0, (a < b), x}; end
            4'd6:  begin x = 32'd0 - a; r = {32'b0, x}; end
            4'd7:  r = {32'b0, a << amt};
            4'd8:  r = {32'b0, a >> amt};
            4'd9:  begin x = $signed(a) >>> amt; r = {32'b0, x}; end
            4'd10: begin repeat (amt) x = {x[30:0], x[31]}; r = {32'b0, x}; end
            4'd11: begin repeat (amt) x = {x[0], x[31:1]}; r = {32'b0, x}; end
            4'd12: begin
                q = longint'($signed(a)) * longint'($signed(b));
                r = q;
            end
            4'd13: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                    z = 1'b1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    m = longint'($signed(a)) % longint'($signed(b));
                    r = {m[31:0], q[31:0]};
                end
            end
            4'd14: r = {32'b0, b};
            default: r = '0;
        endcase
        return {z, r};
    endfunction

    // Scoreboard monitor: every done must match the oldest outstanding request
    always @(negedge clk) begin
        exp_t e;
        if (clr_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 with result %h, expected no done", result);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("busy_at_done", {63'b0, busy}, 64'd0);
            end
        end
    end

    // Wait out any in-flight op (with ignored noise on start), then issue one request
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        int          guard;
        int          lat;
        logic [64:0] mr;
        exp_t        e;
        guard = 0;
        while (busy && guard < 200) begin
            start = 1'($urandom_range(0, 1));
            op    = 4'($urandom);
            A     = $urandom;
            B     = $urandom;
            @(negedge clk);
            guard++;
        end
        if (busy) begin
            n_vec++;
            n_bad++;
            $display("FAIL busy_timeout: busy still %0b after %0d cycles, expected 0", busy, guard);
        end
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        mr    = model(o, a, b);
        lat   = (o == 4'd12 || (o == 4'd13 && b != 32'd0)) ? 32 : 0;
        e.res = mr[63:0];
        e.dbz = mr[64];
        e.due = 32'(cyc + 1 + lat);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int          g;
        logic [3:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        clr_n = 1'b0;
        start = 1'b0;
        op    = '0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_dbz", {63'b0, div_by_zero}, 64'd0);
        clr_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'd4,  32'hFFFF_FFFF, 32'd1);
        issue(4'd11, 32'd1, 32'd33);
        issue(4'd12, 32'hFFFF_FFFD, 32'd7);
        chk("busy_during_mul", {63'b0, busy}, 64'd1);
        issue(4'd13, 32'hFFFF_FFF9, 32'd2);
        issue(4'd13, 32'd5, 32'd0);
        issue(4'd13, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(4'd12, 32'h8000_0000, 32'h8000_0000);
        issue(4'd5,  32'd3, 32'd5);
        issue(4'd9,  32'h8000_0000, 32'hFFFF_FFE4);
        issue(4'd10, 32'h8000_0001, 32'd0);
        issue(4'd15, 32'hDEAD_BEEF, 32'h1234_5678);
        issue(4'd13, 32'd7, 32'hFFFF_FFFE);

        // Reset in the middle of a multiply: no done, all outputs cleared
        issue(4'd12, 32'd1234, 32'd5678);
        repeat (5) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", {63'b0, busy}, 64'd0);
        chk("abort_done", {63'b0, done}, 64'd0);
        chk("abort_result", result, 64'd0);
        chk("abort_dbz", {63'b0, div_by_zero}, 64'd0);
        sb.delete();
        clr_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(4'd0, 32'hF0F0_0000, 32'h0000_0F0F);

        // Randomised traffic, biased toward the corner operands
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
            issue(ro, ra, rb);
        end

        g = 0;
        while (sb.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
